// File: rtl/mem_port_arbiter.sv
// Shares the unified memory port between instruction fetch and data access:
// data-first priority, a fetch anti-starvation streak limit, and a no-response timeout.
module mem_port_arbiter #(
    parameter int unsigned MAX_STREAK = 4,
    parameter int unsigned TIMEOUT    = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic [31:0] if_rdata,
    output logic        if_valid,
    output logic        if_stall,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic [31:0] d_rdata,
    output logic        d_valid,
    output logic        d_stall,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ready,
    output logic        bus_err
);
    localparam logic [2:0] STREAK_SAT = 3'(MAX_STREAK);
    localparam logic [7:0] TMO_LIMIT  = 8'(TIMEOUT);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_BUSY_IF = 2'd1,
        S_BUSY_D  = 2'd2
    } state_t;

    state_t      r_state;
    logic [2:0]  r_streak;
    logic [7:0]  r_tmo;

    state_t      w_state_nxt;
    logic [2:0]  w_streak_nxt;
    logic [7:0]  w_tmo_nxt;
    logic        w_mem_req_nxt;
    logic        w_mem_we_nxt;
    logic [31:0] w_mem_addr_nxt;
    logic [31:0] w_mem_wdata_nxt;
    logic [31:0] w_if_rdata_nxt;
    logic [31:0] w_d_rdata_nxt;
    logic        w_if_valid_nxt;
    logic        w_d_valid_nxt;
    logic        w_bus_err_nxt;

    logic        w_if_cand;
    logic        w_d_cand;
    logic        w_grant_if;
    logic        w_grant_d;

    // A requester holding its completion pulse this cycle is about to drop req, so it sits out.
    assign w_if_cand  = if_req & ~if_valid;
    assign w_d_cand   = d_req & ~d_valid;
    assign w_grant_if = w_if_cand & (~w_d_cand | (r_streak == STREAK_SAT));
    assign w_grant_d  = w_d_cand & ~w_grant_if;

    assign if_stall = if_req & ~if_valid;
    assign d_stall  = d_req & ~d_valid;

    // Next-state and next-output logic for the arbitration / transaction FSM.
    always_comb begin
        w_state_nxt     = r_state;
        w_streak_nxt    = r_streak;
        w_tmo_nxt       = r_tmo;
        w_mem_req_nxt   = mem_req;
        w_mem_we_nxt    = mem_we;
        w_mem_addr_nxt  = mem_addr;
        w_mem_wdata_nxt = mem_wdata;
        w_if_rdata_nxt  = if_rdata;
        w_d_rdata_nxt   = d_rdata;
        w_if_valid_nxt  = 1'b0;
        w_d_valid_nxt   = 1'b0;
        w_bus_err_nxt   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_grant_if) begin
                    w_state_nxt     = S_BUSY_IF;
                    w_mem_req_nxt   = 1'b1;
                    w_mem_we_nxt    = 1'b0;
                    w_mem_addr_nxt  = if_addr;
                    w_mem_wdata_nxt = 32'd0;
                    w_tmo_nxt       = 8'd0;
                    w_streak_nxt    = 3'd0;
                end else if (w_grant_d) begin
                    w_state_nxt     = S_BUSY_D;
                    w_mem_req_nxt   = 1'b1;
                    w_mem_we_nxt    = d_we;
                    w_mem_addr_nxt  = d_addr;
                    w_mem_wdata_nxt = d_wdata;
                    w_tmo_nxt       = 8'd0;
                    if (if_req) begin
                        w_streak_nxt = (r_streak >= STREAK_SAT) ? STREAK_SAT : r_streak + 3'd1;
                    end else begin
                        w_streak_nxt = 3'd0;
                    end
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_BUSY_IF, S_BUSY_D: begin
                if (mem_ready) begin
                    w_state_nxt   = S_IDLE;
                    w_mem_req_nxt = 1'b0;
                    if (r_state == S_BUSY_IF) begin
                        w_if_valid_nxt = 1'b1;
                        w_if_rdata_nxt = mem_rdata;
                    end else begin
                        w_d_valid_nxt = 1'b1;
                        // Stores leave the last load result visible.
                        if (!mem_we) begin
                            w_d_rdata_nxt = mem_rdata;
                        end else begin
                            w_d_rdata_nxt = d_rdata;
                        end
                    end
                end else if (r_tmo == TMO_LIMIT) begin
                    w_state_nxt   = S_IDLE;
                    w_mem_req_nxt = 1'b0;
                    w_bus_err_nxt = 1'b1;
                    if (r_state == S_BUSY_IF) begin
                        w_if_valid_nxt = 1'b1;
                        w_if_rdata_nxt = 32'd0;
                    end else begin
                        w_d_valid_nxt = 1'b1;
                        w_d_rdata_nxt = 32'd0;
                    end
                end else begin
                    w_tmo_nxt = r_tmo + 8'd1;
                end
            end
            default: begin
                w_state_nxt   = S_IDLE;
                w_mem_req_nxt = 1'b0;
            end
        endcase
    end

    // State, counters and all registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_streak  <= 3'd0;
            r_tmo     <= 8'd0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= 32'd0;
            mem_wdata <= 32'd0;
            if_rdata  <= 32'd0;
            d_rdata   <= 32'd0;
            if_valid  <= 1'b0;
            d_valid   <= 1'b0;
            bus_err   <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_streak  <= w_streak_nxt;
            r_tmo     <= w_tmo_nxt;
            mem_req   <= w_mem_req_nxt;
            mem_we    <= w_mem_we_nxt;
            mem_addr  <= w_mem_addr_nxt;
            mem_wdata <= w_mem_wdata_nxt;
            if_rdata  <= w_if_rdata_nxt;
            d_rdata   <= w_d_rdata_nxt;
            if_valid  <= w_if_valid_nxt;
            d_valid   <= w_d_valid_nxt;
            bus_err   <= w_bus_err_nxt;
        end
    end
endmodule
